// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/logic/slt, bit-serial shifts,
// valid/ready handshake on both sides and a synchronous flush.
module alu_exec_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             ltu
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;

  // Single-cycle result; shifts only land here with a zero amount.
  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                               input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:                 r = a + b;
      OP_SUB:                 r = a - b;
      OP_AND:                 r = a & b;
      OP_OR:                  r = a | b;
      OP_XOR:                 r = a ^ b;
      OP_SLT:                 r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: r = a;
      default:                r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] acc,
                                                  input logic             fill);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, acc[WIDTH-1:1]};
      default: r = {fill, acc[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] step_res;
  logic [SHW-1:0]   amt;
  logic             is_shift;

  assign alu_res  = alu_op(ALUControl, srcA, srcB);
  assign step_res = shift_step(op_q, acc_q, sign_q);
  assign amt      = srcB[SHW-1:0];
  assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                    (ALUControl == OP_SRA);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            lt_d  = $signed(srcA) < $signed(srcB);
            ltu_d = srcA < srcB;
            if (is_shift && (amt != '0)) begin
              acc_d   = srcA;
              cnt_d   = amt;
              op_d    = ALUControl;
              sign_d  = srcA[WIDTH-1];
              state_d = SHIFT;
            end else begin
              acc_d   = alu_res;
              zero_d  = (alu_res == '0);
              state_d = DONE;
            end
          end
        end
        SHIFT: begin
          acc_d = step_res;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            zero_d  = (step_res == '0);
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: table of ops with hand-computed
// results and latencies, plus backpressure, flush and reset sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        lt;
  logic        ltu;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .srcA(srcA), .srcB(srcB), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .lt(lt), .ltu(ltu)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        ltu;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accept an op, scramble the inputs, wait for out_valid, check, then drain.
  task automatic run_vec(input vec_t v);
    int lat;
    lat = -1;
    @(negedge clk);
    ALUControl = v.op; srcA = v.a; srcB = v.b; in_valid = 1'b1; out_ready = 1'b0;
    chk1({v.name, " in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; srcA = $urandom; srcB = $urandom; ALUControl = 4'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chkint({v.name, " latency"}, lat, v.lat);
    chk32({v.name, " result"}, result, v.res);
    chk1({v.name, " zero"}, zero, v.z);
    chk1({v.name, " lt"}, lt, v.lt);
    chk1({v.name, " ltu"}, ltu, v.ltu);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1({v.name, " idle after drain"}, in_ready, 1'b1);
  endtask

  task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALUControl = op; srcA = a; srcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin : main
    int lat;
    int seen;
    vecs[0]  = '{"add",      4'd0, 32'd5,        32'd7,        32'd12,       1'b0, 1'b1, 1'b1, 1};
    vecs[1]  = '{"sub_neg",  4'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1};
    vecs[2]  = '{"sub_zero", 4'd1, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{"and",      4'd2, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{"or_zero",  4'd3, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{"xor",      4'd4, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b1, 1'b1, 1};
    vecs[6]  = '{"slt_t",    4'd5, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{"slt_f",    4'd5, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b1, 1};
    vecs[8]  = '{"sra4",     4'd8, 32'h80000000, 32'hFFFFFFE4, 32'hF8000000, 1'b0, 1'b1, 1'b1, 5};
    vecs[9]  = '{"srl4",     4'd7, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 1'b0, 1'b1, 1'b1, 5};
    vecs[10] = '{"sll0",     4'd6, 32'd1,        32'h00000020, 32'd1,        1'b0, 1'b1, 1'b1, 1};
    vecs[11] = '{"sra3_pos", 4'd8, 32'h7FFFFFF0, 32'd3,        32'h0FFFFFFE, 1'b0, 1'b0, 1'b0, 4};
    vecs[12] = '{"sra31",    4'd8, 32'hFFFFFFFF, 32'h1F,       32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32};
    vecs[13] = '{"srl31",    4'd7, 32'h80000000, 32'h1F,       32'd1,        1'b0, 1'b1, 1'b0, 32};
    vecs[14] = '{"sll1",     4'd6, 32'd3,        32'd1,        32'd6,        1'b0, 1'b0, 1'b0, 2};
    vecs[15] = '{"sll_out",  4'd6, 32'h80000000, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 2};
    vecs[16] = '{"rsv_c",    4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0, 1};
    vecs[17] = '{"rsv_9",    4'h9, 32'd0,        32'd1,        32'd0,        1'b1, 1'b1, 1'b1, 1};

    rst_n = 1'b0; in_valid = 1'b0; ALUControl = 4'd0; srcA = '0; srcB = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    chk1("rst out_valid", out_valid, 1'b0);
    chk32("rst result", result, 32'd0);
    chk1("rst zero", zero, 1'b0);
    chk1("rst lt", lt, 1'b0);
    chk1("rst ltu", ltu, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk1("rst in_ready", in_ready, 1'b1);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // sra in_ready low through the whole shift
    accept(4'd8, 32'h80000000, 32'hFFFFFFE4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk1("sra busy in_ready", in_ready, 1'b0);
      chk1("sra out_valid timing", out_valid, k == 5);
    end
    out_ready = 1'b1; @(posedge clk); #1 out_ready = 1'b0;

    // Backpressure with a simultaneous pending in_valid on the release edge
    accept(4'd6, 32'd1, 32'd31);
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    chk1("bp out_valid", seen[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("bp hold valid", out_valid, 1'b1);
      chk32("bp hold result", result, 32'h80000000);
      chk1("bp in_ready low", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; ALUControl = 4'd0; srcA = 32'd1; srcB = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk1("bp released in_ready", in_ready, 1'b1);
    chk1("bp released out_valid", out_valid, 1'b0);

    // Flush at cycle 3 of a 10-bit shift, with a pending in_valid
    accept(4'd6, 32'd1, 32'd10);
    @(negedge clk); @(negedge clk); @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; ALUControl = 4'd0;
    chk1("flush busy in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk1("flush in_ready", in_ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk1("flush no out_valid", seen[0], 1'b0);
    run_vec(vecs[0]);

    // Flush in IDLE blocks the accept; flush in DONE drops the result
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; ALUControl = 4'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk1("flush idle no accept", in_ready, 1'b1);
    accept(4'hC, 32'd0, 32'd0);
    @(negedge clk);
    chk1("done before flush", out_valid, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk1("flush done out_valid", out_valid, 1'b0);

    // Reset pulse mid-shift
    accept(4'd8, 32'h80000000, 32'd10);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk1("mid rst out_valid", out_valid, 1'b0);
    chk32("mid rst result", result, 32'd0);
    chk1("mid rst zero", zero, 1'b0);
    chk1("mid rst lt", lt, 1'b0);
    chk1("mid rst ltu", ltu, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk1("post rst in_ready", in_ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk1("post rst no out_valid", seen[0], 1'b0);
    run_vec(vecs[0]);

    lat = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + lat);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALUControl code produced by the ALU decoder, together with two operands, and returns a registered result with comparison flags.
- Add/sub/logic/slt ops complete in one cycle. Shifts run iteratively at one bit per cycle, which replaces a barrel shifter.
- Sits between operand select and writeback/branch logic. The control unit drives it through a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHW, $clog2(WIDTH), shift-amount width. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and ALUControl are valid.
- in_ready  output  1  unit can accept an op; high only in IDLE.
- ALUControl  input  4  op code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, 9-15 reserved.
- srcA  input  WIDTH  operand A; the value shifted for shift ops.
- srcB  input  WIDTH  operand B; shift amount is srcB[SHW-1:0].
- flush  input  1  synchronous abort of the in-flight op.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  op result.
- zero  output  1  result == 0.
- lt  output  1  signed srcA < srcB, taken from the accepted operands.
- ltu  output  1  unsigned srcA < srcB, taken from the accepted operands.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0; result=0; zero=0; lt=0; ltu=0; shift counter=0. in_ready=1 once reset is released. Reset mid-shift discards the op; no output is produced.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept occurs when in_valid && in_ready at a rising edge; call that edge cycle 0. lt and ltu are captured at accept for every op code.
- Non-shift op, or shift with amount 0: result computed and registered at accept. Transition IDLE->DONE, so out_valid=1 in cycle 1.
- Shift with amount n>0: at accept, acc=srcA, cnt=n, sign bit saved; IDLE->SHIFT.
  - Each SHIFT cycle shifts acc by exactly 1 and decrements cnt.
  - After the n-th shift, SHIFT->DONE. out_valid=1 in cycle n+1.
  - Total latency is n+1 cycles (n = 0..WIDTH-1).
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH; no carry or overflow output.
  - slt: result = {WIDTH-1 zeros, signed(srcA)<signed(srcB)}.
  - srl fills with 0. sra fills with srcA[WIDTH-1] captured at accept.
  - Only srcB[SHW-1:0] is used as the shift amount; upper bits are ignored.
  - Reserved codes 9-15: result=0, zero=1, latency 1.
- zero is computed from the final result and becomes valid together with out_valid.
- DONE: result and all flags hold stable until out_ready=1. DONE->IDLE on the edge where out_valid && out_ready. No new op is accepted in the same edge; minimum throughput is one op per 2 cycles.
- While out_valid=0, the values on result and flags are don't-care for consumers. Internal registers hold their last value.
- flush=1 at an edge in any state: next state is IDLE and out_valid=0 next cycle. flush has priority over accept, shift and out_ready.
- A pending in_valid during flush is not accepted; in_ready is low in that cycle only if state is not IDLE.
- Inputs srcA/srcB/ALUControl may change after accept with no effect on the in-flight op.

Test Plan:
- add: accept ALUControl=0, srcA=5, srcB=7 at cycle 0 -> out_valid=1 at cycle 1, result=12, zero=0, lt=1, ltu=1.
- sub: srcA=3, srcB=5 -> result=0xFFFFFFFE, lt=1, ltu=1 at cycle 1. Then srcA=srcB=0x1234 -> result=0, zero=1.
- sra: srcA=0x80000000, srcB=0xFFFFFFE4 (amount 4) -> in_ready=0 during cycles 1-5, out_valid=1 at cycle 5, result=0xF8000000. srl with the same inputs -> result=0x08000000.
- Backpressure: sll srcA=1, amount 31, out_ready=0 for 3 cycles after out_valid -> result=0x80000000 stable throughout; IDLE and in_ready=1 only after the edge where out_ready=1.
- flush at cycle 3 of an amount-10 shift -> out_valid never asserts, in_ready=1 at cycle 4. Next add accepted normally. Repeat with rst_n pulsed low mid-shift -> all outputs 0 immediately.
- Reserved code 0xC with srcA=srcB=0xFFFFFFFF -> result=0, zero=1, latency 1.
